led_display_driver: RTL and testbench
=====================================

// Module: led_display_driver
// PURPOSE
//   Output-side counterpart to the switch/button capture logic. Accepts an LED pattern over a
//   valid/ready handshake and drives the board LEDs with it.
//   Each accepted pattern shows for a fixed hold time, steady or blinking.
//   Game/test logic posts status patterns here and never touches the LED pins directly.
// PARAMETERS
//   NUM_LEDS     4           number of board LEDs driven
//   CNT_W        24          width of hold and blink counters
//   HOLD_CYCLES  12_000_000  cycles a pattern is displayed before the next is accepted (>=1)
//   BLINK_HALF   3_000_000   cycles per blink half-period, lit then dark (>=1)
// PORTS
//   clk         in   1         board clock
//   rst         in   1         asynchronous, active-high reset
//   in_valid    in   1         request: pattern/blink are valid
//   in_ready    out  1         driver can accept; transfer when in_valid & in_ready
//   in_pattern  in   NUM_LEDS  LED pattern to show
//   in_blink    in   1         1 = blink the pattern during hold, 0 = steady
//   brightness  in   4         PWM level; used only with LED_PWM_DIM_EN, ignored otherwise
//   busy        out  1         pattern is in its hold window
//   led         out  NUM_LEDS  registered LED drive
// BEHAVIOUR
//   - Reset (async): state=IDLE; led=0, busy=0; hold_cnt, blink_cnt, latched pattern/blink cleared.
//   - in_ready = (state==IDLE), combinational from state only.
//   - FSM states:
//     - IDLE: when in_valid is seen, latch in_pattern/in_blink, set hold_cnt=HOLD_CYCLES-1,
//       set blink_cnt=BLINK_HALF-1, phase=lit, and go to SHOW. led=in_pattern and busy=1 on the
//       next cycle (latency 1).
//     - SHOW: hold_cnt decrements each cycle. If blink, blink_cnt decrements; at 0 it reloads
//       BLINK_HALF-1 and phase toggles. led = pattern when phase=lit or !blink, else 0.
//     - SHOW -> IDLE in the cycle hold_cnt==0. The next cycle has busy=0, in_ready=1, and
//       led = latched pattern steady, whatever the blink phase was.
//   - Pattern is visible (busy=1) for exactly HOLD_CYCLES cycles.
//   - Back-to-back: at least one IDLE cycle between transfers.
//   - in_valid while in SHOW: ignored, nothing latched; the requester holds its request.
//   - in_pattern/in_blink changes while in SHOW have no effect.
//   - HOLD_CYCLES=1: SHOW lasts one cycle.
//   - BLINK_HALF >= HOLD_CYCLES: blink pattern is never dark.
//   - Counters are CNT_W unsigned and never wrap below 0 (they reload or exit first).
//   - Reset mid-SHOW: immediate return to reset values; the in-flight pattern is lost.
// CONFIGURATION
//   - Macro LED_PWM_DIM_EN defined:
//     - 4-bit free-running pwm_cnt (reset 0) counts every cycle.
//     - Each lit LED bit is ANDed with (pwm_cnt <= brightness) inside the led register:
//       duty = (brightness+1)/16, brightness=4'hF is full on.
//     - Gating also applies in IDLE. No added latency.
//   - Macro undefined: no PWM logic; brightness unused; led = pattern/blink result only.
// STRUCTURE
//   - Package led_drv_pkg: state typedef (IDLE, SHOW), default HOLD_CYCLES/BLINK_HALF constants,
//     PWM width constant (4).
//   - One sub-module, led_pwm_gate (pwm_cnt + compare, NUM_LEDS-wide AND). Instantiated only
//     under LED_PWM_DIM_EN.
// TESTING (bench params: HOLD_CYCLES=8, BLINK_HALF=2, NUM_LEDS=4)
//   1 Reset: assert rst for 3 cycles, then release -> led=0000, busy=0, in_ready=1.
//   2 Steady: in_valid=1, pattern 1010, blink=0 for one cycle -> led=1010 the next cycle;
//     busy=1 and in_ready=0 for 8 cycles; then in_ready=1 and led stays 1010.
//   3 Blink: pattern 1111, blink=1 -> led over the 8 SHOW cycles = 1111,1111,0000,0000,1111,
//     1111,0000,0000; led=1111 in the following IDLE cycle.
//   4 Ignored request: during SHOW of 0011, pulse in_valid with 0101 -> led stays 0011 for the
//     full window; 0101 never appears.
//   5 Back-to-back and reset: keep in_valid high with 1100 then 0110 -> second accept exactly one
//     IDLE cycle after the first window. Assert rst mid-window -> led=0000, in_ready=1 immediately.
//   6 LED_PWM_DIM_EN, brightness=3, pattern 1111 steady -> each LED high 4 of every 16 cycles;
//     brightness=F -> always high.

Source files
------------

// File: rtl/led_drv_pkg.sv
// Shared types and constants for the LED display driver.
// The optional PWM dimming feature is enabled by defining LED_PWM_DIM_EN.
package led_drv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam int DEF_HOLD_CYCLES = 12_000_000;
  localparam int DEF_BLINK_HALF  = 3_000_000;
  localparam int PWM_W           = 4;

endpackage

// File: rtl/led_pwm_gate.sv
// Brightness gate: free-running PWM counter whose compare masks the LED bits.
// Only instantiated when LED_PWM_DIM_EN is defined.
module led_pwm_gate
  import led_drv_pkg::*;
#(
  parameter int NUM_LEDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_W-1:0]    brightness,
  input  logic [NUM_LEDS-1:0] pattern,
  output logic [NUM_LEDS-1:0] gated
);

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end

  // Duty is (brightness+1)/16, so brightness 4'hF never gates anything off
  assign gated = pattern & {NUM_LEDS{pwm_cnt <= brightness}};

endmodule

// File: rtl/led_display_driver.sv
// Accepts LED patterns over valid/ready and shows each one, steady or blinking, for a hold window.
// Define LED_PWM_DIM_EN to dim the LEDs with a 4-bit PWM driven by the brightness input.
module led_display_driver
  import led_drv_pkg::*;
#(
  parameter int NUM_LEDS    = 4,
  parameter int CNT_W       = 24,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int BLINK_HALF  = DEF_BLINK_HALF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_LEDS-1:0] in_pattern,
  input  logic                in_blink,
  input  logic [PWM_W-1:0]    brightness,
  output logic                busy,
  output logic [NUM_LEDS-1:0] led
);

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_HALF - 1);

  state_t              state, state_next;
  logic [CNT_W-1:0]    hold_cnt, hold_next;
  logic [CNT_W-1:0]    blink_cnt, blink_next;
  logic [NUM_LEDS-1:0] pat_q, pat_next;
  logic                blink_q, blink_q_next;
  logic                phase_q, phase_next;
  logic [NUM_LEDS-1:0] led_next;
  logic [NUM_LEDS-1:0] led_gated;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      pat_q     <= '0;
      blink_q   <= 1'b0;
      phase_q   <= 1'b0;
      led       <= '0;
    end else begin
      state     <= state_next;
      hold_cnt  <= hold_next;
      blink_cnt <= blink_next;
      pat_q     <= pat_next;
      blink_q   <= blink_q_next;
      phase_q   <= phase_next;
      led       <= led_gated;
    end
  end

  // phase_q=1 means the lit half of a blink period; led_next is the value for the next cycle
  always_comb begin
    state_next   = state;
    hold_next    = hold_cnt;
    blink_next   = blink_cnt;
    pat_next     = pat_q;
    blink_q_next = blink_q;
    phase_next   = phase_q;
    led_next     = pat_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next   = SHOW;
          hold_next    = HOLD_LOAD;
          blink_next   = BLINK_LOAD;
          phase_next   = 1'b1;
          pat_next     = in_pattern;
          blink_q_next = in_blink;
          led_next     = in_pattern;
        end
      end
      SHOW: begin
        if (hold_cnt == '0) begin
          // Leaving the window always restores the steady pattern, regardless of blink phase
          state_next = IDLE;
          led_next   = pat_q;
        end else begin
          hold_next = hold_cnt - CNT_W'(1);
          if (blink_q) begin
            if (blink_cnt == '0) begin
              blink_next = BLINK_LOAD;
              phase_next = ~phase_q;
            end else begin
              blink_next = blink_cnt - CNT_W'(1);
            end
          end
          led_next = (!blink_q || phase_next) ? pat_q : '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == SHOW);

`ifdef LED_PWM_DIM_EN
  led_pwm_gate #(
    .NUM_LEDS(NUM_LEDS)
  ) u_pwm_gate (
    .clk       (clk),
    .rst       (rst),
    .brightness(brightness),
    .pattern   (led_next),
    .gated     (led_gated)
  );
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign led_gated         = led_next;
`endif

endmodule

// File: tb/tb_led_display_driver.sv
// Self-checking bench for led_display_driver: window-level reference model plus literal checks.
// Define LED_PWM_DIM_EN to also exercise the PWM dimming path.
module tb_led_display_driver;

  localparam int N = 4;
  localparam int H = 8;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_blink = 1'b0;
  logic [N-1:0] in_pattern = '0;
  logic [3:0]   brightness = 4'hF;
  logic         in_ready;
  logic         busy;
  logic [N-1:0] led;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b1;

  led_display_driver #(
    .NUM_LEDS   (N),
    .CNT_W      (24),
    .HOLD_CYCLES(H),
    .BLINK_HALF (B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pattern(in_pattern),
    .in_blink  (in_blink),
    .brightness(brightness),
    .busy      (busy),
    .led       (led)
  );

  always #5 clk = ~clk;

  // Reference model: position k inside the display window decides lit/dark as (k/B) odd => dark
  bit           m_show = 1'b0;
  int           m_k = 0;
  logic [N-1:0] m_pat = '0;
  logic [N-1:0] m_last = '0;
  bit           m_blk = 1'b0;
  logic [N-1:0] exp_led;
  bit           exp_busy;

  always @(posedge clk) begin
    if (rst) begin
      m_show = 1'b0;
      m_last = '0;
    end else if (m_show) begin
      m_k++;
      if (m_k == H) m_show = 1'b0;
    end else if (in_valid) begin
      m_show = 1'b1;
      m_k    = 0;
      m_pat  = in_pattern;
      m_blk  = in_blink;
      m_last = in_pattern;
    end
    exp_busy = m_show;
    if (m_show) exp_led = (m_blk && ((m_k / B) % 2 == 1)) ? '0 : m_pat;
    else        exp_led = m_last;
    #1;
    if (check_en) begin
      tests++;
      if (led !== exp_led || busy !== exp_busy || in_ready !== !exp_busy) begin
        fails++;
        $display("[TB] FAIL model t=%0t: led=%b busy=%b ready=%b, expected led=%b busy=%b ready=%b",
                 $time, led, busy, in_ready, exp_led, exp_busy, !exp_busy);
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [N-1:0] p, input bit b);
    @(negedge clk);
    in_valid   = v;
    in_pattern = p;
    in_blink   = b;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] e_led, input bit e_busy,
                             input bit e_ready);
    tests++;
    if (led !== e_led || busy !== e_busy || in_ready !== e_ready) begin
      fails++;
      $display("[TB] FAIL %s t=%0t: led=%b busy=%b ready=%b, expected led=%b busy=%b ready=%b",
               name, $time, led, busy, in_ready, e_led, e_busy, e_ready);
    end
  endtask

  logic [N-1:0] blink_seq [8];

  initial begin
    blink_seq = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset", 4'b0000, 1'b0, 1'b1);

    // Steady pattern
    applyStimulus(1'b1, 4'b1010, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < H; i++) begin
      checkOutput("steady_window", 4'b1010, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("steady_after", 4'b1010, 1'b0, 1'b1);

    // Blinking pattern
    applyStimulus(1'b1, 4'b1111, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < H; i++) begin
      checkOutput("blink_window", blink_seq[i], 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("blink_after", 4'b1111, 1'b0, 1'b1);

    // Request during the window is ignored
    applyStimulus(1'b1, 4'b0011, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < H; i++) begin
      if (i == 1) begin
        in_valid   = 1'b1;
        in_pattern = 4'b0101;
      end else if (i == 2) begin
        in_valid   = 1'b0;
        in_pattern = 4'b0000;
      end
      checkOutput("ignored_window", 4'b0011, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("ignored_after", 4'b0011, 1'b0, 1'b1);

    // Back-to-back with a held request, then reset mid-window
    applyStimulus(1'b1, 4'b1100, 1'b0);
    @(negedge clk);
    in_pattern = 4'b0110;
    for (int i = 0; i < H; i++) begin
      checkOutput("b2b_first", 4'b1100, 1'b1, 1'b0);
      @(negedge clk);
    end
    checkOutput("b2b_gap", 4'b1100, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("b2b_second", 4'b0110, 1'b1, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("reset_mid", 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_after", 4'b0000, 1'b0, 1'b1);

    // Randomized traffic with occasional resets, checked by the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid   = ($urandom_range(0, 2) == 0);
      in_pattern = N'($urandom);
      in_blink   = 1'($urandom);
      rst        = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (H + 4) @(negedge clk);

`ifdef LED_PWM_DIM_EN
    // Dimming: count lit cycles per LED over one full PWM period
    applyStimulus(1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    repeat (H + 2) @(negedge clk);
    check_en   = 1'b0;
    brightness = 4'h3;
    @(negedge clk);
    begin
      int cnt [N];
      for (int j = 0; j < N; j++) cnt[j] = 0;
      for (int c = 0; c < 16; c++) begin
        for (int j = 0; j < N; j++) if (led[j]) cnt[j]++;
        @(negedge clk);
      end
      for (int j = 0; j < N; j++) begin
        tests++;
        if (cnt[j] != 4) begin
          fails++;
          $display("[TB] FAIL pwm_dim led%0d: high %0d of 16, expected 4", j, cnt[j]);
        end
      end
      brightness = 4'hF;
      @(negedge clk);
      for (int j = 0; j < N; j++) cnt[j] = 0;
      for (int c = 0; c < 16; c++) begin
        for (int j = 0; j < N; j++) if (led[j]) cnt[j]++;
        @(negedge clk);
      end
      for (int j = 0; j < N; j++) begin
        tests++;
        if (cnt[j] != 16) begin
          fails++;
          $display("[TB] FAIL pwm_full led%0d: high %0d of 16, expected 16", j, cnt[j]);
        end
      end
    end
    check_en = 1'b1;
    repeat (4) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
